poly_pair_streamer: RTL and testbench
=====================================

// Module: poly_pair_streamer
// PURPOSE
//  Transmit side of the coefficient-stream interface consumed by the polynomial multiplier.
//  Buffers one polynomial pair (p in Rq, u in R2) written by the host or key-gen logic.
//  Streams the pair in lockstep on two axis_if.out ports, 1 coeff/clk, 'last' on coeff N-1.
//  Ping-pong banks: the next pair loads while the current pair streams, so streams run back-to-back.
// PARAMETERS
//  N   16  coeffs per polynomial; power of 2, >=2
//  QW  64  p coeff width (Q = 2^QW)
//  UW  1   u coeff width
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  s_rst      in   1         reset; synchronous, active-high
//  wr_en      in   1         coeff write strobe
//  wr_sel     in   1         0: write p, 1: write u
//  wr_addr    in   log2(N)   coeff index
//  wr_data    in   QW        coeff value; u bank stores wr_data[UW-1:0]
//  load_done  in   1         1-cycle pulse: current write bank is complete
//  load_rdy   out  1         write bank is free; writes/load_done accepted
//  load_err   out  1         1-cycle pulse: wr_en or load_done arrived while load_rdy=0
//  p          axis_if.out    data[QW], vld, last out; rdy in
//  u          axis_if.out    data[UW], vld, last out; rdy in
// BEHAVIOUR
//  Reset: p/u.vld=0, .last=0, .data=0; load_rdy=1, load_err=0; both banks empty; wr_bank=rd_bank=0; rd_idx=0; state IDLE.
//  Load:
//   - When load_rdy=1, wr_en writes mem[wr_bank][wr_sel][wr_addr].
//   - When load_rdy=1, load_done marks wr_bank full and toggles wr_bank (next cycle).
//   - load_rdy = !full[wr_bank], registered.
//   - When load_rdy=0, wr_en/load_done are ignored, load_err pulses, and bank contents are unchanged.
//   - Unwritten coeffs keep their previous values; banks are not cleared.
//  Handshake:
//   - Beat accepted iff vld && p.rdy && u.rdy; vld, last and data are identical in timing on p and u.
//   - While vld=1 and no acceptance, data/last are held stable. vld never drops before 'last' is accepted.
//  FSM:
//   - IDLE: if full[rd_bank], go to STREAM. In the next cycle vld=1 with coeff 0 registered on data, so latency load_done -> first vld = 2 clks.
//   - STREAM: on acceptance rd_idx++; data/last register the next coeff.
//   - STREAM: last=1 exactly while rd_idx==N-1.
//   - STREAM: on accepting last, clear full[rd_bank], toggle rd_bank, rd_idx=0.
//   - STREAM: if the other bank is full, stay in STREAM with vld held high (no bubble). Otherwise go to IDLE with vld=0.
//  Boundaries:
//   - load_done and final acceptance in the same cycle (different banks): both take effect. Bank freed that cycle gives load_rdy=1 next cycle.
//   - Both banks full: load_rdy=0 until a stream completes.
//   - rd_idx wraps N-1 -> 0 only via the last-acceptance path.
//   - Reset mid-stream (s_rst high at any cycle): stream abandoned without 'last', all state to reset values at that edge, buffered pairs discarded.
//  Arithmetic: rd_idx is log2(N) bits and never reaches N; no arithmetic on coeff data.
// STRUCTURE
//  fv_enc_pkg: coeff_p_t (logic[QW-1:0]), coeff_u_t (logic[UW-1:0]), tx_state_t {ST_IDLE, ST_STREAM}.
//  Sub-module poly_bank: N-entry register array with sync write and async read.
//  Instantiate 4x (2 banks x {p,u}); the FSM, flags and output registers stay in poly_pair_streamer.
// TESTING (N=4, QW=8, UW=1)
//  1. Reset held 3 clks -> vld=0, last=0, data=0, load_rdy=1, load_err=0.
//  2. Write p={1,2,3,4}, u={1,0,1,1}, load_done, rdy=1 -> vld rises 2 clks after load_done; p 1,2,3,4 / u 1,0,1,1 on consecutive clks; last only on the 4th beat; then vld=0.
//  3. As 2, drop p.rdy for 3 clks while data=2 -> p=2/u=0 held, no beat skipped or repeated; u.rdy low alone stalls identically.
//  4. Load pair A, then pair B (p={5,6,7,8}) during A's stream -> 8 contiguous beats, last on beats 4 and 8; load_rdy=0 while both banks full.
//  5. wr_en with load_rdy=0 (both banks full) -> load_err 1-cycle pulse; streamed data equals the original contents.
//  6. Assert s_rst on beat 2 of a stream -> vld=0 next clk, load_rdy=1; a fresh load streams from coeff 0 with correct last.

Source files
------------

// File: rtl/fv_enc_pkg.sv
// Shared types and defaults for the polynomial pair transmit path.
package fv_enc_pkg;

  localparam int unsigned N_DEF  = 16;
  localparam int unsigned QW_DEF = 64;
  localparam int unsigned UW_DEF = 1;

  typedef logic [QW_DEF-1:0] coeff_p_t;
  typedef logic [UW_DEF-1:0] coeff_u_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } tx_state_t;

endpackage

// File: rtl/poly_pair_streamer_bank.sv
// One polynomial bank: N coefficients, synchronous write, asynchronous read.
// Contents are never cleared; unwritten entries keep their old values.
module poly_bank #(
  parameter  int unsigned N  = 16,
  parameter  int unsigned W  = 64,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [N];

  // Store a coefficient on a write strobe.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/poly_pair_streamer.sv
// Ping-pong buffered transmitter of a (p, u) polynomial pair. Two lockstep
// streams, one coefficient per clock, 'last' on coefficient N-1. One bank
// loads while the other streams so consecutive pairs run without a bubble.
module poly_pair_streamer
  import fv_enc_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  parameter  int unsigned QW = QW_DEF,
  parameter  int unsigned UW = UW_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_s_rst,
  input  logic          i_wr_en,
  input  logic          i_wr_sel,
  input  logic [IW-1:0] i_wr_addr,
  input  logic [QW-1:0] i_wr_data,
  input  logic          i_load_done,
  output logic          o_load_rdy,
  output logic          o_load_err,
  output logic [QW-1:0] o_p_data,
  output logic          o_p_vld,
  output logic          o_p_last,
  input  logic          i_p_rdy,
  output logic [UW-1:0] o_u_data,
  output logic          o_u_vld,
  output logic          o_u_last,
  input  logic          i_u_rdy
);

  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [1:0]    r_full, w_full_nxt;
  logic          r_wr_bank, w_wr_bank_nxt;
  logic          r_rd_bank, w_rd_bank_nxt;
  logic [IW-1:0] r_rd_idx, w_rd_idx_nxt;
  logic          r_vld, w_vld_nxt;
  logic          r_last, w_last_nxt;
  logic [QW-1:0] r_p_data, w_p_data_nxt;
  logic [UW-1:0] r_u_data, w_u_data_nxt;
  logic          r_load_rdy;
  logic          r_load_err;

  logic          w_accept, w_last_beat, w_final_acc, w_load_acc, w_wr_acc;
  logic          w_rsel;
  logic [IW-1:0] w_raddr;
  logic [QW-1:0] w_p_rd [2];
  logic [UW-1:0] w_u_rd [2];
  logic [QW-1:0] w_p_sel;
  logic [UW-1:0] w_u_sel;

  assign w_accept    = r_vld & i_p_rdy & i_u_rdy;
  assign w_last_beat = (r_rd_idx == IDX_LAST);
  assign w_final_acc = w_accept & w_last_beat;
  assign w_load_acc  = i_load_done & r_load_rdy;
  assign w_wr_acc    = i_wr_en & r_load_rdy;

  // Two banks, each holding one p polynomial and one u polynomial.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    poly_bank #(.N(N), .W(QW)) u_p_bank (
      .i_clk   (i_clk),
      .i_we    (w_wr_acc && !i_wr_sel && (r_wr_bank == 1'(b))),
      .i_waddr (i_wr_addr),
      .i_wdata (i_wr_data),
      .i_raddr (w_raddr),
      .o_rdata (w_p_rd[b])
    );
    poly_bank #(.N(N), .W(UW)) u_u_bank (
      .i_clk   (i_clk),
      .i_we    (w_wr_acc && i_wr_sel && (r_wr_bank == 1'(b))),
      .i_waddr (i_wr_addr),
      .i_wdata (i_wr_data[UW-1:0]),
      .i_raddr (w_raddr),
      .o_rdata (w_u_rd[b])
    );
  end

  // Address the coefficient that becomes visible after the next edge:
  // coeff 0 of the bank about to start, otherwise rd_idx+1 of the active bank.
  always_comb begin
    w_rsel  = r_rd_bank;
    w_raddr = IDX_ZERO;
    if (r_state == ST_STREAM) begin
      if (w_last_beat) begin
        w_rsel  = ~r_rd_bank;
        w_raddr = IDX_ZERO;
      end else begin
        w_rsel  = r_rd_bank;
        w_raddr = r_rd_idx + IDX_ONE;
      end
    end else begin
      w_rsel  = r_rd_bank;
      w_raddr = IDX_ZERO;
    end
  end

  assign w_p_sel = w_p_rd[w_rsel];
  assign w_u_sel = w_u_rd[w_rsel];

  // Bank ownership: a completed load fills the write bank, a completed stream
  // frees the read bank. Both may happen together since they target different banks.
  always_comb begin
    w_full_nxt    = r_full;
    w_wr_bank_nxt = r_wr_bank;
    if (w_load_acc) begin
      w_full_nxt[r_wr_bank] = 1'b1;
      w_wr_bank_nxt         = ~r_wr_bank;
    end else begin
      w_wr_bank_nxt = r_wr_bank;
    end
    if (w_final_acc) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end else begin
      w_full_nxt[r_rd_bank] = w_full_nxt[r_rd_bank];
    end
  end

  // Stream FSM: start on a full bank, advance on acceptance, chain into the
  // other bank without a bubble when it is already full.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_idx_nxt  = r_rd_idx;
    w_vld_nxt     = r_vld;
    w_last_nxt    = r_last;
    w_p_data_nxt  = r_p_data;
    w_u_data_nxt  = r_u_data;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt  = ST_STREAM;
          w_rd_idx_nxt = IDX_ZERO;
          w_vld_nxt    = 1'b1;
          w_last_nxt   = 1'b0;
          w_p_data_nxt = w_p_sel;
          w_u_data_nxt = w_u_sel;
        end else begin
          w_vld_nxt  = 1'b0;
          w_last_nxt = 1'b0;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          if (w_last_beat) begin
            w_rd_bank_nxt = ~r_rd_bank;
            w_rd_idx_nxt  = IDX_ZERO;
            if (r_full[~r_rd_bank]) begin
              w_vld_nxt    = 1'b1;
              w_last_nxt   = 1'b0;
              w_p_data_nxt = w_p_sel;
              w_u_data_nxt = w_u_sel;
            end else begin
              w_state_nxt  = ST_IDLE;
              w_vld_nxt    = 1'b0;
              w_last_nxt   = 1'b0;
              w_p_data_nxt = {QW{1'b0}};
              w_u_data_nxt = {UW{1'b0}};
            end
          end else begin
            w_rd_idx_nxt = r_rd_idx + IDX_ONE;
            w_last_nxt   = (w_raddr == IDX_LAST);
            w_p_data_nxt = w_p_sel;
            w_u_data_nxt = w_u_sel;
          end
        end else begin
          w_vld_nxt = r_vld;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_vld_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State, flags and output registers; reset discards any buffered pairs.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_state    <= ST_IDLE;
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_idx   <= IDX_ZERO;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_p_data   <= {QW{1'b0}};
      r_u_data   <= {UW{1'b0}};
      r_load_rdy <= 1'b1;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_full     <= w_full_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_vld      <= w_vld_nxt;
      r_last     <= w_last_nxt;
      r_p_data   <= w_p_data_nxt;
      r_u_data   <= w_u_data_nxt;
      r_load_rdy <= ~w_full_nxt[w_wr_bank_nxt];
      r_load_err <= (i_wr_en | i_load_done) & ~r_load_rdy;
    end
  end

  assign o_load_rdy = r_load_rdy;
  assign o_load_err = r_load_err;
  assign o_p_data   = r_p_data;
  assign o_p_vld    = r_vld;
  assign o_p_last   = r_last;
  assign o_u_data   = r_u_data;
  assign o_u_vld    = r_vld;
  assign o_u_last   = r_last;

endmodule

// File: tb/tb_poly_pair_streamer.sv
// Self-checking bench for poly_pair_streamer (N=4, QW=8, UW=1).
module tb_poly_pair_streamer;

  localparam int N  = 4;
  localparam int QW = 8;
  localparam int UW = 1;

  logic          clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          wr_en = 1'b0, wr_sel = 1'b0, load_done = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [QW-1:0] wr_data = 8'd0;
  logic          p_rdy = 1'b1, u_rdy = 1'b1;
  logic          o_load_rdy, o_load_err;
  logic [QW-1:0] o_p_data;
  logic [UW-1:0] o_u_data;
  logic          o_p_vld, o_p_last, o_u_vld, o_u_last;

  always #5 clk = ~clk;

  poly_pair_streamer #(.N(N), .QW(QW), .UW(UW)) dut (
    .i_clk(clk), .i_s_rst(s_rst), .i_wr_en(wr_en), .i_wr_sel(wr_sel),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_load_done(load_done),
    .o_load_rdy(o_load_rdy), .o_load_err(o_load_err),
    .o_p_data(o_p_data), .o_p_vld(o_p_vld), .o_p_last(o_p_last), .i_p_rdy(p_rdy),
    .o_u_data(o_u_data), .o_u_vld(o_u_vld), .o_u_last(o_u_last), .i_u_rdy(u_rdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat as seen on the bus: {p, u, last}.
  typedef logic [QW+1:0] beat_t;
  beat_t got_q[$];
  int    err_pulses = 0;

  // Bus monitor: records accepted beats, checks lockstep and stall stability.
  initial begin
    logic  hold_pend;
    beat_t hold_b;
    hold_pend = 1'b0;
    hold_b    = '0;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        hold_pend = 1'b0;
      end else begin
        chk("lockstep", {o_u_vld, o_u_last}, {o_p_vld, o_p_last});
        if (hold_pend) begin
          chk("stall_vld", o_p_vld, 1'b1);
          chk("stall_data", {o_p_data, o_u_data, o_p_last}, hold_b);
        end
        if (o_p_vld && p_rdy && u_rdy) got_q.push_back({o_p_data, o_u_data, o_p_last});
        hold_pend = o_p_vld && !(p_rdy && u_rdy);
        hold_b    = {o_p_data, o_u_data, o_p_last};
        if (o_load_err) err_pulses++;
      end
    end
  end

  // Write the masked coefficients of a pair, optionally with idle gaps, then pulse load_done.
  task automatic write_pair(input logic [N-1:0][QW-1:0] pv, input logic [N-1:0] uv,
                            input logic [N-1:0] pm, input logic [N-1:0] um, input bit gaps);
    for (int i = 0; i < 2 * N; i++) begin
      int k;
      k = i % N;
      if ((i < N) ? pm[k] : um[k]) begin
        wr_en   = 1'b1;
        wr_sel  = (i >= N);
        wr_addr = 2'(k);
        wr_data = QW'($urandom);
        if (i < N) wr_data = pv[k];
        else       wr_data[0] = uv[k];
        step();
        wr_en = 1'b0;
      end
      if (gaps && $urandom_range(0, 3) == 0) step();
    end
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  typedef struct {
    logic          we, sel;
    logic [1:0]    a;
    logic [QW-1:0] d;
    logic          ld;
    logic          ev, el, cd;
    logic [QW-1:0] ep;
    logic          eu, er, ee;
  } vec_t;

  function automatic vec_t mk(logic we, logic sel, logic [1:0] a, logic [QW-1:0] d, logic ld,
                              logic ev, logic el, logic cd, logic [QW-1:0] ep, logic eu,
                              logic er, logic ee);
    vec_t v;
    v.we = we; v.sel = sel; v.a = a; v.d = d; v.ld = ld;
    v.ev = ev; v.el = el; v.cd = cd; v.ep = ep; v.eu = eu; v.er = er; v.ee = ee;
    return v;
  endfunction

  logic [N-1:0][QW-1:0] pa, pb, pc, pd, pe;
  logic [N-1:0]         ua, ub, uc, ud, ue;

  initial begin
    vec_t vecs[$];
    logic [QW-1:0] mp [2][N];
    logic          mu [2][N];
    beat_t         exp_q[$];
    int            wb;
    bit            done;

    pa = {8'd4, 8'd3, 8'd2, 8'd1};     ua = 4'b1101;
    pb = {8'd8, 8'd7, 8'd6, 8'd5};     ub = 4'b1010;
    pc = {8'd12, 8'd11, 8'd10, 8'd9};  uc = 4'b0011;
    pd = {8'd16, 8'd15, 8'd14, 8'd13}; ud = 4'b0101;
    pe = {8'd24, 8'd23, 8'd22, 8'd21}; ue = 4'b1110;

    // 1. reset held three clocks
    repeat (3) step();
    chk("rst_vld", {o_p_vld, o_u_vld}, 2'b00);
    chk("rst_last", {o_p_last, o_u_last}, 2'b00);
    chk("rst_data", {o_p_data, o_u_data}, 9'd0);
    chk("rst_load_rdy", o_load_rdy, 1'b1);
    chk("rst_load_err", o_load_err, 1'b0);
    s_rst = 1'b0;

    // 2. basic pair, table driven; u writes carry junk in the upper bits
    vecs.push_back(mk(1, 0, 0, 8'd1,   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 8'd2,   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 2, 8'd3,   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 8'd4,   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8'hF1,  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 8'hA0,  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 2, 8'h37,  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3, 8'h03,  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   0, 1, 0, 1, 8'd1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   0, 1, 0, 1, 8'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   0, 1, 0, 1, 8'd3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   0, 1, 1, 1, 8'd4, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0, 0, 1, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].we; wr_sel = vecs[i].sel; wr_addr = vecs[i].a;
      wr_data = vecs[i].d; load_done = vecs[i].ld;
      step();
      chk($sformatf("t2_vld[%0d]", i), o_p_vld, vecs[i].ev);
      chk($sformatf("t2_last[%0d]", i), o_p_last, vecs[i].el);
      chk($sformatf("t2_load_rdy[%0d]", i), o_load_rdy, vecs[i].er);
      chk($sformatf("t2_load_err[%0d]", i), o_load_err, vecs[i].ee);
      if (vecs[i].cd) chk($sformatf("t2_data[%0d]", i), {o_p_data, o_u_data}, {vecs[i].ep, vecs[i].eu});
    end
    wr_en = 1'b0; load_done = 1'b0;

    // 3. stall on p.rdy then on u.rdy
    got_q.delete();
    write_pair(pa, ua, 4'hF, 4'hF, 1'b0);
    step();
    chk("t3_first", {o_p_vld, o_p_data, o_u_data, o_p_last}, {1'b1, 8'd1, 1'b1, 1'b0});
    step();
    p_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_p_stall", {o_p_vld, o_p_data, o_u_data}, {1'b1, 8'd2, 1'b0});
      step();
    end
    p_rdy = 1'b1;
    chk("t3_p_stall_end", {o_p_data, o_u_data}, {8'd2, 1'b0});
    step();
    chk("t3_beat3", {o_p_data, o_u_data, o_p_last}, {8'd3, 1'b1, 1'b0});
    step();
    u_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t3_u_stall", {o_p_vld, o_p_data, o_u_data, o_p_last}, {1'b1, 8'd4, 1'b1, 1'b1});
      step();
    end
    u_rdy = 1'b1;
    step();
    chk("t3_end_vld", o_p_vld, 1'b0);
    chk("t3_beats", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < N; i++)
      chk($sformatf("t3_beat%0d", i), got_q[i], {pa[i], ua[i], (i == N - 1)});

    // 4/5. both banks full, rejected writes, then 8 back-to-back beats
    p_rdy = 1'b0; u_rdy = 1'b0;
    write_pair(pa, ua, 4'hF, 4'hF, 1'b0);
    write_pair(pb, ub, 4'hF, 4'hF, 1'b0);
    chk("t4_rdy_full", o_load_rdy, 1'b0);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd1; wr_data = 8'hEE;
    step();
    chk("t5_err_wr", o_load_err, 1'b1);
    wr_en = 1'b0; load_done = 1'b1;
    step();
    chk("t5_err_ld", o_load_err, 1'b1);
    load_done = 1'b0; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd1; wr_data = 8'h01;
    step();
    chk("t5_err_wr_u", o_load_err, 1'b1);
    wr_en = 1'b0;
    step();
    chk("t5_err_clear", o_load_err, 1'b0);
    chk("t5_rdy_still_full", o_load_rdy, 1'b0);
    p_rdy = 1'b1; u_rdy = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      logic [QW-1:0] ep;
      logic          eu;
      ep = (k < N) ? pa[k % N] : pb[k % N];
      eu = (k < N) ? ua[k % N] : ub[k % N];
      chk($sformatf("t4_vld%0d", k), o_p_vld, 1'b1);
      chk($sformatf("t4_beat%0d", k), {o_p_data, o_u_data, o_p_last}, {ep, eu, (k % N == N - 1)});
      if (k == N - 1) chk("t4_rdy_before_free", o_load_rdy, 1'b0);
      if (k == N)     chk("t4_rdy_after_free", o_load_rdy, 1'b1);
      step();
    end
    chk("t4_end_vld", o_p_vld, 1'b0);

    // 6. reset in the middle of a stream with a second pair buffered
    p_rdy = 1'b0; u_rdy = 1'b0;
    write_pair(pc, uc, 4'hF, 4'hF, 1'b0);
    write_pair(pd, ud, 4'hF, 4'hF, 1'b0);
    p_rdy = 1'b1; u_rdy = 1'b1;
    step();
    chk("t6_beat2", {o_p_vld, o_p_data}, {1'b1, 8'd10});
    s_rst = 1'b1;
    step();
    chk("t6_rst_vld_last", {o_p_vld, o_u_vld, o_p_last}, 3'b000);
    chk("t6_rst_data", {o_p_data, o_u_data}, 9'd0);
    chk("t6_rst_rdy_err", {o_load_rdy, o_load_err}, 2'b10);
    s_rst = 1'b0;
    got_q.delete();
    write_pair(pe, ue, 4'hF, 4'hF, 1'b0);
    repeat (12) step();
    chk("t6_beats", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < N; i++)
      chk($sformatf("t6_beat%0d", i), got_q[i], {pe[i], ue[i], (i == N - 1)});

    // Random phase: partial rewrites, random back-pressure, pair-level model
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    got_q.delete();
    err_pulses = 0;
    wb = 0;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [N-1:0][QW-1:0] pv;
          logic [N-1:0]         uv, pm, um;
          int                   wait_c;
          wait_c = 0;
          while (!o_load_rdy && wait_c < 100) begin
            step();
            wait_c++;
          end
          if (wait_c >= 100) begin
            chk("rand_load_rdy_timeout", 1'b0, 1'b1);
            break;
          end
          for (int i = 0; i < N; i++) begin
            pv[i] = QW'($urandom);
            uv[i] = 1'($urandom);
          end
          pm = (k < 2) ? 4'hF : 4'($urandom);
          um = (k < 2) ? 4'hF : 4'($urandom);
          for (int i = 0; i < N; i++) begin
            if (pm[i]) mp[wb][i] = pv[i];
            if (um[i]) mu[wb][i] = uv[i];
            exp_q.push_back({mp[wb][i], mu[wb][i], (i == N - 1)});
          end
          wb = 1 - wb;
          write_pair(pv, uv, pm, um, 1'b1);
        end
        begin
          int wait_c;
          wait_c = 0;
          while (got_q.size() < exp_q.size() && wait_c < 2000) begin
            step();
            wait_c++;
          end
          if (wait_c >= 2000) chk("rand_drain_timeout", 1'b0, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          p_rdy = ($urandom_range(0, 3) != 0);
          u_rdy = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    p_rdy = 1'b1; u_rdy = 1'b1;
    repeat (4) step();
    chk("rand_beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rand_beat%0d", i), got_q[i], exp_q[i]);
    chk("rand_no_load_err", err_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
